gig_eth_mac_tx_arbiter: RTL and testbench
=========================================

// Module: gig_eth_mac_tx_arbiter
// PURPOSE
//  Frame-level round-robin arbiter sharing the single GbE MAC TX client stream between
//  NUM_PORTS byte-wide AXIS requesters. Sits directly in front of gig_eth_mac TX, in tx_clk.
//  Grants one whole frame at a time, never interleaves bytes, and counts per-port frames.
// PARAMETERS
//  NUM_PORTS   2   number of requesters (2..4)
//  CNT_WIDTH   16  width of each per-port frame / error counter (wraps)
// PORTS
//  tx_clk              in   1              single clock, all logic
//  reset               in   1              synchronous, active-high
//  conf_arb_en         in   1              1 = new grants allowed; sampled only in IDLE
//  s_axis_tdata        in   8*NUM_PORTS    requester data, port i at [8i+7:8i]
//  s_axis_tvalid       in   NUM_PORTS      requester valid
//  s_axis_tlast        in   NUM_PORTS      requester end of frame
//  s_axis_tuser        in   NUM_PORTS      requester bad-frame flag (valid with tlast)
//  s_axis_tready       out  NUM_PORTS      requester ready
//  tx_axis_mac_tdata   out  8              to MAC TX client
//  tx_axis_mac_tvalid  out  1
//  tx_axis_mac_tlast   out  1
//  tx_axis_mac_tuser   out  1
//  tx_axis_mac_tready  in   1              from MAC TX client
//  grant_onehot        out  NUM_PORTS      current owner, 0 in IDLE
//  frame_cnt           out  CNT_WIDTH*NUM_PORTS  frames completed per port
//  err_cnt             out  CNT_WIDTH*NUM_PORTS  frames completed with tuser=1 per port
// BEHAVIOUR
//  - Reset: state=IDLE, grant_onehot=0, last_grant=NUM_PORTS-1 (port 0 first), all counters
//    0, s_axis_tready=0, tx_axis_mac_tvalid/tlast/tuser=0, tx_axis_mac_tdata=0.
//    Reset mid-frame abandons the frame; no tlast emitted; MAC handles underrun.
//  - FSM IDLE: if conf_arb_en and |s_axis_tvalid, choose first port with tvalid searching
//    last_grant+1, +2, ... modulo NUM_PORTS; register grant_onehot; -> BUSY next cycle.
//    Arbitration latency exactly 1 cycle; no tready asserted in IDLE.
//  - FSM BUSY: combinational pass-through of granted port: tx_axis_mac_* = s_axis_*[g];
//    s_axis_tready[g]=tx_axis_mac_tready, all other tready=0. Non-granted outputs zero.
//    On tx_axis_mac_tvalid & tready & tlast: last_grant<=g, frame_cnt[g]++,
//    err_cnt[g]++ if tuser, grant_onehot<=0, -> IDLE.
//  - Minimum cost: 1 idle cycle between frames (IDLE arbitration); MAC IFG hides it.
//  - Granted port dropping tvalid mid-frame: grant held, output tvalid=0 (MAC underruns);
//    arbiter never preempts.
//  - conf_arb_en low during BUSY: current frame completes; no new grant afterwards.
//  - Requests that arrive in the same cycle as a grant are not lost; they win later in order.
//  - Counters wrap modulo 2^CNT_WIDTH, no saturation.
//  - tdata/tlast/tuser outside tvalid are don't-care on inputs, forced 0 on outputs.
// STRUCTURE
//  - Shared package gig_eth_mac_pkg: FSM state enum (ARB_IDLE, ARB_BUSY), MAX_ARB_PORTS=4.
//  - One sub-module: gig_eth_rr_pick (combinational: req vector + last_grant -> one-hot).
//  - Top: FSM, grant register, muxes, counters. Target ~200 lines RTL.
// TESTING
//  1 Port0 sends 64-byte frame, port1 idle, tready=1 -> 64 beats out, 1-cycle grant gap,
//    frame_cnt[0]=1, s_axis_tready[1]=0 throughout.
//  2 Both ports hold 60-byte frames continuously -> order 0,1,0,1; 4 frames, never mixed
//    bytes; frame_cnt=2/2.
//  3 Port1 requests while port0 mid-frame -> port1 granted 1 cycle after port0 tlast beat.
//  4 tready toggles 1010.. during frame -> output matches input byte-for-byte, no duplicate
//    or dropped beats; tready back-pressure reaches granted port only.
//  5 Port0 frame ends tuser=1 -> tx_axis_mac_tuser=1 on tlast beat; err_cnt[0]=1.
//  6 conf_arb_en=0 with pending requests -> no grant; assert reset mid-frame -> all
//    outputs 0 next cycle, port 0 wins first after release.

Source files
------------

// File: rtl/gig_eth_mac_pkg.sv
// Shared types for the GbE MAC TX client-side arbiter.
// Holds the arbiter state encoding and port-count limits.
package gig_eth_mac_pkg;

    localparam int MAX_ARB_PORTS = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gig_eth_rr_pick.sv
// Combinational round-robin picker: first requester after last_i,
// wrapping modulo NUM_PORTS, returned one-hot.
module gig_eth_rr_pick
    import gig_eth_mac_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    localparam int IW = idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IW-1:0]        last_i,
    output logic [NUM_PORTS-1:0] grant_o
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = IW'((int'(last_i) + i) % NUM_PORTS);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gig_eth_mac_tx_arbiter.sv
// Frame-level round-robin arbiter feeding the single GbE MAC TX stream.
// Whole frames only; per-port frame and bad-frame counters.
module gig_eth_mac_tx_arbiter
    import gig_eth_mac_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                           tx_clk,
    input  logic                           reset,
    input  logic                           conf_arb_en,
    input  logic [8*NUM_PORTS-1:0]         s_axis_tdata,
    input  logic [NUM_PORTS-1:0]           s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]           s_axis_tlast,
    input  logic [NUM_PORTS-1:0]           s_axis_tuser,
    output logic [NUM_PORTS-1:0]           s_axis_tready,
    output logic [7:0]                     tx_axis_mac_tdata,
    output logic                           tx_axis_mac_tvalid,
    output logic                           tx_axis_mac_tlast,
    output logic                           tx_axis_mac_tuser,
    input  logic                           tx_axis_mac_tready,
    output logic [NUM_PORTS-1:0]           grant_onehot,
    output logic [CNT_WIDTH*NUM_PORTS-1:0] frame_cnt,
    output logic [CNT_WIDTH*NUM_PORTS-1:0] err_cnt
);

    localparam int IW = idx_w(NUM_PORTS);

    arb_state_e                           state_q;
    logic [NUM_PORTS-1:0]                 grant_q;
    logic [IW-1:0]                        last_q;
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]  frame_cnt_q;
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]  err_cnt_q;
    logic [NUM_PORTS-1:0][7:0]            sdata;
    logic [NUM_PORTS-1:0]                 pick;
    logic [IW-1:0]                        gidx;
    logic                                 eof;

    assign sdata        = s_axis_tdata;
    assign grant_onehot = grant_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_cnt      = err_cnt_q;

    gig_eth_rr_pick #(
        .NUM_PORTS(NUM_PORTS)
    ) u_pick (
        .req_i  (s_axis_tvalid),
        .last_i (last_q),
        .grant_o(pick)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q[i]) gidx = IW'(i);
        end
    end

    // Pass-through of the owner; sideband forced to 0 outside tvalid
    always_comb begin
        tx_axis_mac_tvalid = 1'b0;
        tx_axis_mac_tdata  = '0;
        tx_axis_mac_tlast  = 1'b0;
        tx_axis_mac_tuser  = 1'b0;
        s_axis_tready      = '0;
        if (state_q == ARB_BUSY) begin
            tx_axis_mac_tvalid  = s_axis_tvalid[gidx];
            s_axis_tready[gidx] = tx_axis_mac_tready;
            if (s_axis_tvalid[gidx]) begin
                tx_axis_mac_tdata = sdata[gidx];
                tx_axis_mac_tlast = s_axis_tlast[gidx];
                tx_axis_mac_tuser = s_axis_tuser[gidx];
            end
        end
    end

    assign eof = tx_axis_mac_tvalid & tx_axis_mac_tready & tx_axis_mac_tlast;

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            last_q      <= IW'(NUM_PORTS - 1);
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (conf_arb_en && |s_axis_tvalid) begin
                        grant_q <= pick;
                        state_q <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (eof) begin
                        last_q            <= gidx;
                        frame_cnt_q[gidx] <= frame_cnt_q[gidx] + CNT_WIDTH'(1);
                        if (tx_axis_mac_tuser)
                            err_cnt_q[gidx] <= err_cnt_q[gidx] + CNT_WIDTH'(1);
                        grant_q <= '0;
                        state_q <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gig_eth_mac_tx_arbiter.sv
// Scoreboard bench for gig_eth_mac_tx_arbiter with two requesters.
// Expected beats are queued as frames are scheduled and popped on MAC handshakes.
module tb_gig_eth_mac_tx_arbiter;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct {
        int         port;
        logic [7:0] data;
        logic       last;
        logic       user;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        conf_arb_en;
    logic [15:0] s_axis_tdata;
    logic [1:0]  s_axis_tvalid;
    logic [1:0]  s_axis_tlast;
    logic [1:0]  s_axis_tuser;
    logic [1:0]  s_axis_tready;
    logic [7:0]  tx_axis_mac_tdata;
    logic        tx_axis_mac_tvalid;
    logic        tx_axis_mac_tlast;
    logic        tx_axis_mac_tuser;
    logic        tx_axis_mac_tready;
    logic [1:0]  grant_onehot;
    logic [31:0] frame_cnt;
    logic [31:0] err_cnt;

    gig_eth_mac_tx_arbiter #(
        .NUM_PORTS(2),
        .CNT_WIDTH(16)
    ) dut (
        .tx_clk            (clk),
        .reset             (reset),
        .conf_arb_en       (conf_arb_en),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tuser      (s_axis_tuser),
        .s_axis_tready     (s_axis_tready),
        .tx_axis_mac_tdata (tx_axis_mac_tdata),
        .tx_axis_mac_tvalid(tx_axis_mac_tvalid),
        .tx_axis_mac_tlast (tx_axis_mac_tlast),
        .tx_axis_mac_tuser (tx_axis_mac_tuser),
        .tx_axis_mac_tready(tx_axis_mac_tready),
        .grant_onehot      (grant_onehot),
        .frame_cnt         (frame_cnt),
        .err_cnt           (err_cnt)
    );

    always #5 clk = ~clk;

    beat_t src0[$];
    beat_t src1[$];
    exp_t  sb[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit rst_req  = 1'b1;
    bit arb_req  = 1'b1;
    int tready_mode = 0;
    bit acc[2];
    int req_cyc[2];
    int start_cyc = 0;
    int tlast_cyc = 0;
    bit in_frame  = 1'b0;
    bit gap_chk   = 1'b0;
    int exp_fc[2];
    int exp_ec[2];

    function automatic logic [7:0] dat(input int p, input int seed, input int i);
        return 8'(seed * 37 + i * 5 + p * 101);
    endfunction

    task automatic load_frame(input int p, input int len, input bit user, input int seed);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = dat(p, seed, i);
            b.last = (i == len - 1);
            b.user = (i == len - 1) ? user : 1'b0;
            if (p == 0) src0.push_back(b);
            else        src1.push_back(b);
        end
    endtask

    task automatic expect_frame(input int p, input int len, input bit user, input int seed);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.port = p;
            e.data = dat(p, seed, i);
            e.last = (i == len - 1);
            e.user = (i == len - 1) ? user : 1'b0;
            sb.push_back(e);
        end
        exp_fc[p]++;
        if (user) exp_ec[p]++;
    endtask

    // Source drivers and output monitor, all sampled mid-cycle
    initial begin
        beat_t      b;
        exp_t       e;
        logic [1:0] eg;
        reset = 1'b1;
        conf_arb_en = 1'b0;
        s_axis_tdata = '0;
        s_axis_tvalid = '0;
        s_axis_tlast = '0;
        s_axis_tuser = '0;
        tx_axis_mac_tready = 1'b0;
        acc[0] = 1'b0;
        acc[1] = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (acc[0] && src0.size() > 0) void'(src0.pop_front());
            if (acc[1] && src1.size() > 0) void'(src1.pop_front());
            reset = rst_req;
            conf_arb_en = arb_req;
            tx_axis_mac_tready = (tready_mode == 0) ? 1'b1 : cyc[0];
            if (src0.size() > 0) begin
                b = src0[0];
                if (!s_axis_tvalid[0]) req_cyc[0] = cyc;
                s_axis_tvalid[0] = 1'b1;
                s_axis_tdata[7:0] = b.data;
                s_axis_tlast[0] = b.last;
                s_axis_tuser[0] = b.user;
            end else begin
                s_axis_tvalid[0] = 1'b0;
                s_axis_tdata[7:0] = '0;
                s_axis_tlast[0] = 1'b0;
                s_axis_tuser[0] = 1'b0;
            end
            if (src1.size() > 0) begin
                b = src1[0];
                if (!s_axis_tvalid[1]) req_cyc[1] = cyc;
                s_axis_tvalid[1] = 1'b1;
                s_axis_tdata[15:8] = b.data;
                s_axis_tlast[1] = b.last;
                s_axis_tuser[1] = b.user;
            end else begin
                s_axis_tvalid[1] = 1'b0;
                s_axis_tdata[15:8] = '0;
                s_axis_tlast[1] = 1'b0;
                s_axis_tuser[1] = 1'b0;
            end
            #1;
            for (int p = 0; p < 2; p++) begin
                acc[p] = !reset && s_axis_tvalid[p] && s_axis_tready[p];
                checks++;
                if (!grant_onehot[p]) begin
                    if (s_axis_tready[p] !== 1'b0) begin
                        failures++;
                        $display("FAIL tready_iso cyc=%0d port=%0d got=%b want=0",
                                 cyc, p, s_axis_tready[p]);
                    end
                end else if (s_axis_tready[p] !== tx_axis_mac_tready) begin
                    failures++;
                    $display("FAIL tready_pass cyc=%0d port=%0d got=%b want=%b",
                             cyc, p, s_axis_tready[p], tx_axis_mac_tready);
                end
            end
            if (!tx_axis_mac_tvalid) begin
                checks++;
                if ({tx_axis_mac_tdata, tx_axis_mac_tlast, tx_axis_mac_tuser} !== 10'd0) begin
                    failures++;
                    $display("FAIL idle_zero cyc=%0d got=%h/%b/%b want=0",
                             cyc, tx_axis_mac_tdata, tx_axis_mac_tlast, tx_axis_mac_tuser);
                end
            end
            if (reset) in_frame = 1'b0;
            if (!reset && tx_axis_mac_tvalid && tx_axis_mac_tready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat cyc=%0d got=%h want=none",
                             cyc, tx_axis_mac_tdata);
                end else begin
                    e = sb.pop_front();
                    eg = '0;
                    eg[e.port] = 1'b1;
                    if (tx_axis_mac_tdata !== e.data || tx_axis_mac_tlast !== e.last ||
                        tx_axis_mac_tuser !== e.user || grant_onehot !== eg) begin
                        failures++;
                        $display("FAIL beat cyc=%0d got=%h/%b/%b g=%b want=%h/%b/%b g=%b",
                                 cyc, tx_axis_mac_tdata, tx_axis_mac_tlast,
                                 tx_axis_mac_tuser, grant_onehot,
                                 e.data, e.last, e.user, eg);
                    end
                    if (!in_frame) begin
                        in_frame = 1'b1;
                        start_cyc = cyc;
                        if (gap_chk && tlast_cyc > 0) begin
                            checks++;
                            if (cyc != tlast_cyc + 2) begin
                                failures++;
                                $display("FAIL grant_gap start=%0d want=%0d",
                                         cyc, tlast_cyc + 2);
                            end
                        end
                    end
                    if (tx_axis_mac_tlast) begin
                        in_frame = 1'b0;
                        tlast_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() > 0 || src0.size() > 0 || src1.size() > 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL drain_timeout left=%0d want=0", sb.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (frame_cnt[16*p +: 16] !== 16'(exp_fc[p])) begin
                failures++;
                $display("FAIL %s frame_cnt[%0d] got=%0d want=%0d",
                         tag, p, frame_cnt[16*p +: 16], exp_fc[p]);
            end
            checks++;
            if (err_cnt[16*p +: 16] !== 16'(exp_ec[p])) begin
                failures++;
                $display("FAIL %s err_cnt[%0d] got=%0d want=%0d",
                         tag, p, err_cnt[16*p +: 16], exp_ec[p]);
            end
        end
    endtask

    task automatic flush_model();
        src0.delete();
        src1.delete();
        sb.delete();
        exp_fc[0] = 0;
        exp_fc[1] = 0;
        exp_ec[0] = 0;
        exp_ec[1] = 0;
        tlast_cyc = 0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst_req = 1'b1;
        flush_model();
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (grant_onehot !== 2'b00 || s_axis_tready !== 2'b00) begin
            failures++;
            $display("FAIL reset_grant got=%b/%b want=00/00", grant_onehot, s_axis_tready);
        end
        checks++;
        if ({tx_axis_mac_tvalid, tx_axis_mac_tlast, tx_axis_mac_tuser, tx_axis_mac_tdata} !== 11'd0) begin
            failures++;
            $display("FAIL reset_out got=%b%b%b/%h want=0", tx_axis_mac_tvalid,
                     tx_axis_mac_tlast, tx_axis_mac_tuser, tx_axis_mac_tdata);
        end
        check_counters("reset");
        rst_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        gap_chk = 1'b0;
        load_frame(0, 64, 1'b0, 1);
        expect_frame(0, 64, 1'b0, 1);
        wait_drain(400);
        checks++;
        if (start_cyc != req_cyc[0] + 1) begin
            failures++;
            $display("FAIL arb_latency start=%0d want=%0d", start_cyc, req_cyc[0] + 1);
        end
        check_counters("single");
    endtask

    task automatic test_round_robin();
        test_reset();
        gap_chk = 1'b1;
        load_frame(0, 60, 1'b0, 2);
        load_frame(0, 60, 1'b0, 3);
        load_frame(1, 60, 1'b0, 4);
        load_frame(1, 60, 1'b0, 5);
        expect_frame(0, 60, 1'b0, 2);
        expect_frame(1, 60, 1'b0, 4);
        expect_frame(0, 60, 1'b0, 3);
        expect_frame(1, 60, 1'b0, 5);
        wait_drain(800);
        check_counters("rr");
        gap_chk = 1'b0;
    endtask

    task automatic test_late_request();
        int n = 0;
        tlast_cyc = 0;
        gap_chk = 1'b1;
        load_frame(0, 40, 1'b0, 6);
        expect_frame(0, 40, 1'b0, 6);
        expect_frame(1, 20, 1'b0, 7);
        while (sb.size() > 50 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        load_frame(1, 20, 1'b0, 7);
        wait_drain(400);
        check_counters("late");
        gap_chk = 1'b0;
    endtask

    task automatic test_backpressure();
        tready_mode = 1;
        load_frame(1, 30, 1'b0, 8);
        expect_frame(1, 30, 1'b0, 8);
        wait_drain(400);
        tready_mode = 0;
        check_counters("bp");
    endtask

    task automatic test_bad_frame();
        load_frame(0, 10, 1'b1, 9);
        expect_frame(0, 10, 1'b1, 9);
        wait_drain(200);
        check_counters("tuser");
    endtask

    task automatic test_disable_and_reset();
        int n = 0;
        arb_req = 1'b0;
        load_frame(0, 30, 1'b0, 10);
        load_frame(1, 30, 1'b0, 11);
        repeat (20) @(posedge clk);
        #2;
        checks++;
        if (grant_onehot !== 2'b00 || tx_axis_mac_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL arb_disabled got=%b/%b want=00/0", grant_onehot, tx_axis_mac_tvalid);
        end
        expect_frame(1, 30, 1'b0, 11);
        expect_frame(0, 30, 1'b0, 10);
        arb_req = 1'b1;
        while (sb.size() > 50 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        rst_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        checks++;
        if (grant_onehot !== 2'b00 || s_axis_tready !== 2'b00 ||
            {tx_axis_mac_tvalid, tx_axis_mac_tlast, tx_axis_mac_tuser, tx_axis_mac_tdata} !== 11'd0) begin
            failures++;
            $display("FAIL midframe_reset got=%b/%b/%b%b%b/%h want=0", grant_onehot,
                     s_axis_tready, tx_axis_mac_tvalid, tx_axis_mac_tlast,
                     tx_axis_mac_tuser, tx_axis_mac_tdata);
        end
        @(posedge clk);
        #1;
        flush_model();
        check_counters("midreset");
        rst_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        load_frame(1, 12, 1'b0, 12);
        load_frame(0, 12, 1'b0, 13);
        expect_frame(0, 12, 1'b0, 13);
        expect_frame(1, 12, 1'b0, 12);
        wait_drain(200);
        check_counters("post_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout cyc=%0d want=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_late_request();
        test_backpressure();
        test_bad_frame();
        test_disable_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
